serial_add_sched: RTL and testbench
===================================

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter ADD_LATENCY, default 10: cycles from add_start first sampled high until add_sum is final and stable.
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  out  NREQ  one-hot grant/accept strobe.
REQ-007 SHALL have port req_a  in  NREQ*8  packed operand A, requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_b  in  NREQ*8  packed operand B, same packing.
REQ-009 SHALL have port add_start  out  1  start to the shared serial adder.
REQ-010 SHALL have port add_a, add_b  out  8 each  operands to the serial adder.
REQ-011 SHALL have port add_sum  in  9  serial adder result.
REQ-012 SHALL have port rsp_valid  out  1  result available.
REQ-013 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-014 SHALL have ports rsp_sum  out  9 (result) and rsp_id  out  $clog2(NREQ) (index of the granted requester).

Function
REQ-015 SHALL implement states IDLE, RUN, RESP; one operation in flight at most.
REQ-016 IDLE: if any req_valid, SHALL assert req_ready[g] for the winner g in that same cycle, latch req_a/req_b slice g and g, and go to RUN; otherwise stay in IDLE.
REQ-017 RUN: SHALL hold add_start=1 and add_a/add_b at the latched operands; cycle counter runs 0..ADD_LATENCY; at counter==ADD_LATENCY, SHALL capture add_sum into rsp_sum and go to RESP.
REQ-018 RESP: SHALL drive add_start=0 and rsp_valid=1; on rsp_valid&rsp_ready SHALL go to IDLE; otherwise SHALL hold rsp_sum/rsp_id stable.
REQ-019 add_start SHALL be 0 in IDLE and RESP, so the adder sees start low for at least 1 cycle between operations.
REQ-020 Latency SHALL be exactly: grant cycle T, RUN T+1..T+ADD_LATENCY+1, rsp_valid first high at T+ADD_LATENCY+2.
REQ-021 SHALL grant no requester while in RUN or RESP; a stalled rsp_ready SHALL block all new grants.
REQ-022 req_valid SHALL be sampled only in IDLE; a withdrawn request before grant SHALL simply not be served.
REQ-023 rsp_sum SHALL be the unmodified 9-bit add_sum; no truncation or sign handling.

Reset
REQ-024 On resetn low, SHALL immediately force state IDLE, counter 0, add_start 0, req_ready 0, rsp_valid 0, rsp_sum 0, rsp_id 0, add_a/add_b 0, and arbitration pointer 0.
REQ-025 Reset mid-RUN or mid-RESP SHALL discard the operation without a response; the first grant after reset SHALL follow the reset pointer.

Configuration
REQ-026 With SERIAL_SCHED_RR_EN defined, SHALL arbitrate round-robin: search from pointer p upward with wrap; after granting g, p becomes (g+1) mod NREQ.
REQ-027 Without SERIAL_SCHED_RR_EN, SHALL use fixed priority, lowest index wins, no pointer register.

Structure
REQ-028 Package serial_sched_pkg SHALL hold the state enum (IDLE, RUN, RESP), operand width 8, and sum width 9.
REQ-029 Arbitration SHALL live in sub-module rr_arbiter (req vector, pointer, one-hot grant out), instantiated once.

Verification
REQ-030 Single request: req 1, A=200, B=100 -> req_ready[1] at T, rsp_valid at T+12, rsp_sum=300, rsp_id=1.
REQ-031 All four valid continuously, RR on -> grant order 0,1,2,3,0; A=255, B=255 for each -> rsp_sum=510.
REQ-032 Same stimulus, RR off -> requester 0 granted every time, others starved.
REQ-033 rsp_ready held low 5 cycles in RESP -> rsp_sum/rsp_id stable, no req_ready pulses, add_start=0 throughout.
REQ-034 resetn low at T+5 during RUN -> add_start=0 immediately, no response; next request served with full latency and a correct sum.
REQ-035 Back-to-back ops A=0, B=0 then A=1, B=255 -> sums 0 then 256; add_start low at least 1 cycle between them.

Source files
------------

// File: rtl/serial_sched_pkg.sv
// rtl/serial_sched_pkg.sv - shared types and widths for the serial adder scheduler
//
// Purpose: FSM state encoding plus operand/sum widths used by
//          serial_add_sched and its testbench.
// Ports:   none (package).
package serial_sched_pkg;

  localparam int OP_W  = 8;
  localparam int SUM_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority one-hot arbiter
//
// Purpose: grants the first asserted request found searching upward from
//          ptr with wrap-around. With ptr tied to 0 it is a plain
//          lowest-index-wins priority arbiter.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IW    index searched first (must be < NREQ)
//   grant out NREQ  one-hot grant, all zero when req is zero
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_rot_gnt;
  logic [2*NREQ-1:0] w_gnt_dbl;

  // Rotate so that bit 0 of w_rot is requester ptr.
  assign w_rot     = NREQ'({req, req} >> ptr);
  // Isolate lowest set bit (two's complement trick).
  assign w_rot_gnt = w_rot & (~w_rot + NREQ'(1));
  // Rotate the grant back and fold the wrapped half down.
  assign w_gnt_dbl = {{NREQ{1'b0}}, w_rot_gnt} << ptr;
  assign grant     = w_gnt_dbl[2*NREQ-1:NREQ] | w_gnt_dbl[NREQ-1:0];

endmodule

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - schedules NREQ requesters onto one multi-cycle serial adder
//
// Purpose: accepts one request at a time, holds add_start and operands for
//          ADD_LATENCY+1 cycles, captures add_sum and presents it on a
//          valid/ready response port tagged with the requester index.
//          Optional build macro SERIAL_SCHED_RR_EN selects round-robin
//          arbitration; otherwise fixed priority (lowest index wins).
// Ports:
//   clock      in   1          rising-edge clock
//   resetn     in   1          asynchronous active-low reset
//   req_valid  in   NREQ       per-requester request
//   req_ready  out  NREQ       one-hot accept strobe (IDLE only)
//   req_a/b    in   NREQ*8     packed operands, requester i at [8i+7:8i]
//   add_start  out  1          start to the serial adder, high in RUN
//   add_a/b    out  8          latched operands
//   add_sum    in   9          adder result
//   rsp_valid  out  1          result available (RESP)
//   rsp_ready  in   1          consumer accepts result
//   rsp_sum    out  9          captured add_sum
//   rsp_id     out  clog2(NREQ) index of the served requester
module serial_add_sched
  import serial_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int ADD_LATENCY = 10
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OP_W-1:0]     req_a,
  input  logic [NREQ*OP_W-1:0]     req_b,
  output logic                     add_start,
  output logic [OP_W-1:0]          add_a,
  output logic [OP_W-1:0]          add_b,
  input  logic [SUM_W-1:0]         add_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [SUM_W-1:0]         rsp_sum,
  output logic [$clog2(NREQ)-1:0]  rsp_id
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ADD_LATENCY + 1);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [OP_W-1:0]  r_a;
  logic [OP_W-1:0]  r_b;
  logic [SUM_W-1:0] r_sum;
  logic [IW-1:0]    r_id;

  logic [NREQ-1:0]  w_grant;
  logic [IW-1:0]    w_ptr;
  logic [IW-1:0]    w_gid;
  logic [OP_W-1:0]  w_sel_a;
  logic [OP_W-1:0]  w_sel_b;
  logic             w_take;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (w_ptr),
    .grant (w_grant)
  );

  // Encode the one-hot grant and pick that requester's operand slices.
  always_comb begin
    w_gid   = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gid   = IW'(i);
        w_sel_a = req_a[i*OP_W +: OP_W];
        w_sel_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  assign w_take = (r_state == IDLE) && (|req_valid);

`ifdef SERIAL_SCHED_RR_EN
  logic [IW-1:0] r_ptr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_gid == IW'(NREQ - 1)) ? '0 : w_gid + IW'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_gid;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // add_sum is final in the cycle where the counter hits ADD_LATENCY.
          if (r_cnt == CW'(ADD_LATENCY)) begin
            r_sum   <= add_sum;
            r_cnt   <= '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by resetn so no accept strobe escapes while reset is held.
  assign req_ready = (resetn && (r_state == IDLE)) ? w_grant : '0;
  assign add_start = (r_state == RUN);
  assign add_a     = r_a;
  assign add_b     = r_b;
  assign rsp_valid = (r_state == RESP);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - scoreboard bench for serial_add_sched
module tb_serial_add_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 10;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        add_start;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [8:0]  add_sum;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [8:0]  rsp_sum;
  logic [1:0]  rsp_id;

  always #5 clock = ~clock;

  serial_add_sched #(
    .NREQ        (NREQ),
    .ADD_LATENCY (LAT)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  // Serial adder: result is wrong until start has been sampled LAT times.
  int add_cnt = 0;
  always @(posedge clock) begin
    if (!add_start) add_cnt <= 0;
    else if (add_cnt < LAT) add_cnt <= add_cnt + 1;
  end
  assign add_sum = (add_cnt == LAT) ? ({1'b0, add_a} + {1'b0, add_b})
                                    : ~({1'b0, add_a} + {1'b0, add_b});

  typedef struct {
    int id;
    int sum;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Transaction-level reference: one op in flight, response due LAT+2 after grant.
  bit   m_busy = 0;
  int   m_gnt  = 0;
  int   m_ptr  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i = (p + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [3:0] v, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy);
    logic [3:0] e_rdy;
    bit         e_start;
    bit         e_rv;
    int         g;
    @(negedge clock);
    cyc++;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    #1;
    e_start = m_busy && (cyc >= m_gnt + 1) && (cyc <= m_gnt + LAT + 1);
    e_rv    = m_busy && (cyc >= m_gnt + LAT + 2);
    e_rdy   = '0;
    g       = -1;
    if (!m_busy && v != 0) begin
      g = pick(v, m_ptr);
      e_rdy[g] = 1'b1;
      exp_q.push_back('{id: g,
                        sum: int'(a[g*8 +: 8]) + int'(b[g*8 +: 8]),
                        due: cyc + LAT + 2});
    end
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("add_start", 32'(add_start), 32'(e_start));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    if (e_rv && rdy) m_busy = 0;
    if (g >= 0) begin
      m_busy = 1;
      m_gnt  = cyc;
`ifdef SERIAL_SCHED_RR_EN
      m_ptr  = (g + 1) % NREQ;
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    cyc++;
    resetn    = 1'b0;
    req_valid = 4'($urandom_range(1, 15));
    rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_add_start", 32'(add_start), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_add_a",     32'(add_a),     0);
    chk("rst_add_b",     32'(add_b),     0);
    chk("rst_rsp_sum",   32'(rsp_sum),   0);
    chk("rst_rsp_id",    32'(rsp_id),    0);
    m_busy = 0;
    m_ptr  = 0;
    exp_q.delete();
    @(posedge clock);
    #1;
    resetn    = 1'b1;
    req_valid = '0;
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    bit in_rsp = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!resetn) begin
        in_rsp = 0;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected cyc=%0d got sum=%0d id=%0d expected no response",
                   cyc, rsp_sum, rsp_id);
        end else begin
          if (!in_rsp) chk("rsp_latency", 32'(cyc), 32'(exp_q[0].due));
          in_rsp = 1;
          chk("rsp_sum", 32'(rsp_sum), 32'(exp_q[0].sum));
          chk("rsp_id",  32'(rsp_id),  32'(exp_q[0].id));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            in_rsp = 0;
          end
        end
      end
    end
  end

  initial begin
    do_reset();

    // Single request on requester 1: 200 + 100.
    cycle(4'b0010, 32'h0000_C800, 32'h0000_6400, 1'b1);
    for (int i = 0; i < LAT + 4; i++) cycle(4'b0000, '0, '0, 1'b1);

    // All requesters valid continuously with 255 + 255.
    for (int i = 0; i < 5 * (LAT + 3); i++) cycle(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < LAT + 3; i++) cycle(4'b0000, '0, '0, 1'b1);

    // Consumer stall in RESP with requests pending.
    do_reset();
    cycle(4'hF, 32'h1122_3344, 32'h5566_7788, 1'b0);
    for (int i = 0; i < LAT + 1 + 5; i++) cycle(4'hF, 32'h99AA_BBCC, 32'hDDEE_FF00, 1'b0);
    for (int i = 0; i < LAT + 4; i++) cycle(4'b0000, '0, '0, 1'b1);

    // Reset during RUN, then a full-latency op afterwards.
    cycle(4'b0100, 32'h0012_0000, 32'h0034_0000, 1'b1);
    for (int i = 0; i < 4; i++) cycle(4'b0000, '0, '0, 1'b1);
    do_reset();
    cycle(4'b1000, 32'h8000_0000, 32'h8100_0000, 1'b1);
    for (int i = 0; i < LAT + 4; i++) cycle(4'b0000, '0, '0, 1'b1);

    // Reset during RESP.
    cycle(4'b0001, 32'h0000_0007, 32'h0000_0009, 1'b0);
    for (int i = 0; i < LAT + 3; i++) cycle(4'b0000, '0, '0, 1'b0);
    do_reset();

    // Back-to-back: 0+0 then 1+255.
    cycle(4'b0001, 32'h0000_0000, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 2 * (LAT + 3); i++) cycle(4'b0001, 32'h0000_0001, 32'h0000_00FF, 1'b1);
    for (int i = 0; i < LAT + 3; i++) cycle(4'b0000, '0, '0, 1'b1);

    // Random traffic: withdrawn requests, stalls, mixed operands.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] v;
      v = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      cycle(v, $urandom, $urandom, ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 3 * (LAT + 3); i++) cycle(4'b0000, '0, '0, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
